// File: rtl/c_scale_stage_pkg.sv
// Shared definitions for the c_scale_stage channel scaler.
//   DW_DEF / CW_DEF : default channel word and coefficient widths
//   Q15_ONE         : unsigned Q1.15 unity coefficient (table reset value)
//   FRAC_BITS       : fractional bits dropped after the multiply
//   ROUND_K         : half-LSB added before the shift (round half up)
//   sm_word_t       : sign-magnitude channel word at the default width
package c_scale_stage_pkg;

    localparam int DW_DEF    = 12;
    localparam int CW_DEF    = 16;
    localparam int FRAC_BITS = 15;
    localparam int ROUND_K   = 1 << (FRAC_BITS - 1);

    localparam logic [CW_DEF-1:0] Q15_ONE = 16'h8000;

    typedef struct packed {
        logic                sign;
        logic [DW_DEF-2:0]   mag;
    } sm_word_t;

endpackage

// File: rtl/c_scale_stage_lane.sv
// c_scale_lane: one channel of the scaler.
// Captures the word together with its coefficient and bypass flag at the
// acceptance edge, multiplies over PIPE-1 product registers, then rounds,
// saturates, applies bypass and canonicalises negative zero into the output
// register. Total latency is PIPE+1 enabled edges.
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   en          global pipeline advance
//   accept      a new word is captured this edge (in_valid && en)
//   vld         valid bit of each internal stage (index 0 = capture stage)
//   din         sign-magnitude input word
//   coef,bypass table entry belonging to din
//   dout        registered sign-magnitude output word
//   sat         saturation happening at this edge (output register loads)
module c_scale_lane
    import c_scale_stage_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int PIPE = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            en,
    input  logic            accept,
    input  logic [PIPE-1:0] vld,
    input  logic [DW-1:0]   din,
    input  logic [CW-1:0]   coef,
    input  logic            bypass,
    output logic [DW-1:0]   dout,
    output logic            sat
);

    localparam int MW = DW - 1;     // magnitude width
    localparam int PW = MW + CW;    // full product width

    localparam logic [PW:0] MAXV = (PW+1)'((1 << MW) - 1);
    localparam logic [PW:0] RND  = (PW+1)'(ROUND_K);

    // capture stage: word plus the table entry seen at the acceptance edge
    logic          sign0_reg;
    logic [MW-1:0] mag0_reg;
    logic          byp0_reg;
    logic [CW-1:0] coef0_reg;
    logic [PW-1:0] prod0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sign0_reg <= 1'b0;
            mag0_reg  <= '0;
            byp0_reg  <= 1'b0;
            coef0_reg <= '0;
        end else if (en && accept) begin
            sign0_reg <= din[DW-1];
            mag0_reg  <= din[MW-1:0];
            byp0_reg  <= bypass;
            coef0_reg <= coef;
        end
    end

    assign prod0 = PW'(mag0_reg) * PW'(coef0_reg);

    logic          sign_last;
    logic [MW-1:0] mag_last;
    logic          byp_last;
    logic [PW-1:0] prod_last;

    generate
        if (PIPE > 1) begin : g_mul
            logic [PIPE-1:1] sign_reg;
            logic [PIPE-1:1] byp_reg;
            logic [MW-1:0]   mag_reg  [1:PIPE-1];
            logic [PW-1:0]   prod_reg [1:PIPE-1];

            // product register 1 takes the multiply, later ones only delay it
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sign_reg <= '0;
                    byp_reg  <= '0;
                    for (int i = 1; i < PIPE; i++) begin
                        mag_reg[i]  <= '0;
                        prod_reg[i] <= '0;
                    end
                end else if (en) begin
                    if (vld[0]) begin
                        sign_reg[1] <= sign0_reg;
                        byp_reg[1]  <= byp0_reg;
                        mag_reg[1]  <= mag0_reg;
                        prod_reg[1] <= prod0;
                    end
                    for (int i = 2; i < PIPE; i++) begin
                        if (vld[i-1]) begin
                            sign_reg[i] <= sign_reg[i-1];
                            byp_reg[i]  <= byp_reg[i-1];
                            mag_reg[i]  <= mag_reg[i-1];
                            prod_reg[i] <= prod_reg[i-1];
                        end
                    end
                end
            end

            assign sign_last = sign_reg[PIPE-1];
            assign byp_last  = byp_reg[PIPE-1];
            assign mag_last  = mag_reg[PIPE-1];
            assign prod_last = prod_reg[PIPE-1];
        end else begin : g_comb
            assign sign_last = sign0_reg;
            assign byp_last  = byp0_reg;
            assign mag_last  = mag0_reg;
            assign prod_last = prod0;
        end
    endgenerate

    logic [PW:0]   rounded;
    logic          over;
    logic [MW-1:0] mag_res;
    logic          sign_res;

    always_comb begin
        rounded = ({1'b0, prod_last} + RND) >> FRAC_BITS;
        over    = !byp_last && (rounded > MAXV);
        if (byp_last) begin
            mag_res = mag_last;
        end else if (over) begin
            mag_res = MAXV[MW-1:0];
        end else begin
            mag_res = rounded[MW-1:0];
        end
        // a zero magnitude never carries a sign bit, bypass included
        sign_res = sign_last && (mag_res != '0);
    end

    assign sat = en && vld[PIPE-1] && over;

    logic [DW-1:0] dout_reg;

    // only real vectors load the output register; bubbles leave it untouched
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dout_reg <= '0;
        end else if (en && vld[PIPE-1]) begin
            dout_reg <= {sign_res, mag_res};
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/c_scale_stage.sv
// c_scale_stage: per-channel coefficient scaler for NCH sign-magnitude lanes.
// A single valid/ready pipeline (advance en = out_ready || !out_valid) feeds
// NCH c_scale_lane instances. A coefficient/bypass table, written through the
// cfg_* port, is sampled into each lane at the acceptance edge so in-flight
// vectors are unaffected by later writes.
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   in_valid/in_ready       input handshake, in_data packs channel k at k*DW
//   out_valid/out_ready     output handshake, out_data same packing
//   cfg_we/addr/coef/bypass table write (addresses >= NCH are dropped)
//   cfg_clr_sat             clears sat_sticky (a coincident new set wins)
//   sat_sticky              per-channel saturation-occurred flags
module c_scale_stage
    import c_scale_stage_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int PIPE = 2,
    localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*DW-1:0] out_data,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [CW-1:0]     cfg_coef,
    input  logic              cfg_bypass,
    input  logic              cfg_clr_sat,
    output logic [NCH-1:0]    sat_sticky
);

    logic en;
    logic accept;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // stage valid bits: index 0 is the capture stage inside every lane
    logic [PIPE-1:0] vld_reg;
    logic            out_valid_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (en) begin
            vld_reg[0] <= in_valid;
            for (int i = 1; i < PIPE; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
            out_valid_reg <= vld_reg[PIPE-1];
        end
    end

    assign out_valid = out_valid_reg;

    // coefficient table; resets to unity gain in bypass
    logic [CW-1:0]  coef_tbl [NCH];
    logic [NCH-1:0] byp_tbl;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                coef_tbl[i] <= CW'(Q15_ONE);
            end
            byp_tbl <= '1;
        end else if (cfg_we) begin
            // no entry matches an address >= NCH, so such writes vanish
            for (int i = 0; i < NCH; i++) begin
                if (int'(cfg_addr) == i) begin
                    coef_tbl[i] <= cfg_coef;
                    byp_tbl[i]  <= cfg_bypass;
                end
            end
        end
    end

    logic [NCH-1:0] sat_vec;
    logic [NCH-1:0] sat_sticky_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            c_scale_lane #(
                .DW   (DW),
                .CW   (CW),
                .PIPE (PIPE)
            ) u_lane (
                .CLK    (CLK),
                .RESET  (RESET),
                .en     (en),
                .accept (accept),
                .vld    (vld_reg),
                .din    (in_data[gi*DW +: DW]),
                .coef   (coef_tbl[gi]),
                .bypass (byp_tbl[gi]),
                .dout   (out_data[gi*DW +: DW]),
                .sat    (sat_vec[gi])
            );
        end
    endgenerate

    // clear first, then OR in this edge's saturations so a new set wins
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sat_sticky_reg <= '0;
        end else begin
            sat_sticky_reg <= (sat_sticky_reg & ~{NCH{cfg_clr_sat}}) | sat_vec;
        end
    end

    assign sat_sticky = sat_sticky_reg;

endmodule

// File: tb/tb_c_scale_stage.sv
// Self-checking bench for c_scale_stage: directed cases for the documented
// corner behaviour plus a randomized stream with random back-pressure and
// table writes, compared against an arithmetic reference model.
module tb_c_scale_stage;
    import c_scale_stage_pkg::*;

    localparam int NCH  = 8;
    localparam int DW   = DW_DEF;
    localparam int CW   = CW_DEF;
    localparam int PIPE = 2;
    localparam int VW   = NCH * DW;
    localparam int MAXM = (1 << (DW - 1)) - 1;

    logic           CLK;
    logic           RESET;
    logic           in_valid;
    logic           in_ready;
    logic [VW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [VW-1:0]  out_data;
    logic           cfg_we;
    logic [2:0]     cfg_addr;
    logic [CW-1:0]  cfg_coef;
    logic           cfg_bypass;
    logic           cfg_clr_sat;
    logic [NCH-1:0] sat_sticky;

    c_scale_stage #(
        .NCH  (NCH),
        .DW   (DW),
        .CW   (CW),
        .PIPE (PIPE)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_coef    (cfg_coef),
        .cfg_bypass  (cfg_bypass),
        .cfg_clr_sat (cfg_clr_sat),
        .sat_sticky  (sat_sticky)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // reference state: table, sticky flags of retired vectors, expected outputs
    logic [CW-1:0]  m_coef [NCH];
    logic           m_byp  [NCH];
    logic [NCH-1:0] m_sticky;

    typedef struct {
        logic [VW-1:0]  data;
        logic [NCH-1:0] sat;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model_vec(input logic [VW-1:0] d);
        exp_t               e;
        sm_word_t           w;
        longint unsigned    m;
        e.data = '0;
        e.sat  = '0;
        for (int k = 0; k < NCH; k++) begin
            w = d[k*DW +: DW];
            if (m_byp[k]) begin
                m = longint'(w.mag);
            end else begin
                m = (longint'(w.mag) * longint'(m_coef[k]) + longint'(ROUND_K)) >> FRAC_BITS;
                if (m > longint'(MAXM)) begin
                    m = longint'(MAXM);
                    e.sat[k] = 1'b1;
                end
            end
            e.data[k*DW +: DW] = {(m != 0) && w.sign, m[DW-2:0]};
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input logic [DW-1:0] w);
        logic [VW-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DW +: DW] = w;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [DW-1:0] w;
        for (int k = 0; k < NCH; k++) begin
            w = DW'($urandom);
            if ($urandom_range(0, 7) == 0) w[DW-2:0] = '0;
            v[k*DW +: DW] = w;
        end
        return v;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NCH; k++) begin
            m_coef[k] = Q15_ONE;
            m_byp[k]  = 1'b1;
        end
        m_sticky = '0;
        exp_q.delete();
    endtask

    // One clock: called and returns just after a falling edge.
    task automatic step(input logic iv, input logic [VW-1:0] d, input logic ordy,
                        input logic we, input logic [2:0] addr, input logic [CW-1:0] coef,
                        input logic byp, input logic clr, output logic acc);
        logic       pop;
        logic [NCH-1:0] front_sat;
        in_valid    = iv;
        in_data     = d;
        out_ready   = ordy;
        cfg_we      = we;
        cfg_addr    = addr;
        cfg_coef    = coef;
        cfg_bypass  = byp;
        cfg_clr_sat = clr;
        #1;
        check("in_ready", in_ready, ordy || !out_valid);
        acc = iv && (ordy || !out_valid);
        pop = out_valid && ordy;
        if (pop && exp_q.size() > 0) begin
            m_sticky |= exp_q[0].sat;
            void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back(model_vec(d));
        if (we && int'(addr) < NCH) begin
            m_coef[addr] = coef;
            m_byp[addr]  = byp;
        end
        if (clr) m_sticky = '0;
        @(negedge CLK);
        front_sat = '0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                check("out_data", out_data, exp_q[0].data);
                front_sat = exp_q[0].sat;
            end
        end
        check("sat_sticky", sat_sticky, m_sticky | front_sat);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, a);
    endtask

    task automatic send(input logic [VW-1:0] d);
        logic a;
        step(1'b1, d, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, a);
        check("send_accepted", in_ready, 1'b1);
    endtask

    task automatic cfg(input logic [2:0] addr, input logic [CW-1:0] coef, input logic byp);
        logic a;
        step(1'b0, '0, 1'b1, 1'b1, addr, coef, byp, 1'b0, a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            idle(1);
            n++;
        end
        check("drain_done", (exp_q.size() != 0) || out_valid, 1'b0);
    endtask

    task automatic do_reset();
        RESET       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        cfg_we      = 1'b0;
        cfg_clr_sat = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        reset_model();
        @(posedge CLK);
        #1;
        check("rst_out_data", out_data, '0);
        check("rst_sat_sticky", sat_sticky, '0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge CLK);
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] vecs [10];
        logic          a;
        int            got;
        int            cyc;

        in_data    = '0;
        cfg_addr   = '0;
        cfg_coef   = '0;
        cfg_bypass = 1'b0;
        do_reset();

        // default table is bypass: 0x123 everywhere emerges unchanged after PIPE+1
        v = fill_vec(12'h123);
        for (int n = 1; n <= PIPE + 3; n++) begin
            step(n == 1, v, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, a);
            check("latency_out_valid", out_valid, n == PIPE + 1);
        end

        // rounding half up with sign preserved on channel 2
        cfg(3'd2, 16'h4000, 1'b0);
        v = rand_vec();
        v[2*DW +: DW] = 12'h864;
        send(v);
        v = rand_vec();
        v[2*DW +: DW] = 12'h865;
        send(v);
        drain();

        // saturation on channel 3, then clear
        cfg(3'd3, 16'hFFFF, 1'b0);
        v = fill_vec(12'h000);
        v[3*DW +: DW] = 12'h7FF;
        send(v);
        drain();
        check("sticky3_set", sat_sticky[3], 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b1, a);
        check("sticky_cleared", sat_sticky, '0);

        // clear coincident with a new saturation: the set survives
        send(v);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b1, a);
        check("set_wins", sat_sticky[3], 1'b1);
        drain();

        // negative zero canonicalised: scaled (ch6) and bypass (ch0)
        cfg(3'd6, 16'h0001, 1'b0);
        v = rand_vec();
        v[6*DW +: DW] = 12'h801;
        v[0*DW +: DW] = 12'h800;
        send(v);
        drain();

        // ten-vector stream with out_ready low for three cycles
        for (int i = 0; i < 10; i++) vecs[i] = rand_vec();
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 40) begin
            step(1'b1, vecs[got], !(cyc >= 4 && cyc < 7), 1'b0, 3'd0, '0, 1'b0, 1'b0, a);
            if (a) got++;
            cyc++;
        end
        check("stream_all_accepted", got, 10);
        drain();

        // table write on the acceptance edge: N old coefficient, N+1 new
        cfg(3'd7, 16'h8000, 1'b0);
        v = rand_vec();
        v[7*DW +: DW] = 12'h190;
        step(1'b1, v, 1'b1, 1'b1, 3'd7, 16'h2000, 1'b0, 1'b0, a);
        send(v);
        drain();

        // random traffic with back-pressure and table writes
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 3'($urandom), CW'($urandom),
                 $urandom_range(0, 3) == 0, 1'b0, a);
        end
        drain();
        step(1'b0, '0, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b1, a);

        // reset with two vectors in flight: nothing may emerge
        send(rand_vec());
        send(rand_vec());
        do_reset();
        for (int i = 0; i < PIPE + 4; i++) begin
            idle(1);
            check("flushed_out_valid", out_valid, 1'b0);
        end
        send(fill_vec(12'h9AB));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/c_scale_stage.md
C_SCALE_STAGE -- requirements
Module: c_scale_stage

Interface
REQ-001 Parameter NCH, default 8, number of parallel channels per sample vector.
REQ-002 Parameter DW, default 12, channel word width, sign-magnitude (bit DW-1 sign, bits DW-2:0 magnitude).
REQ-003 Parameter CW, default 16, coefficient width, unsigned Q1.15 (0x8000 = 1.0).
REQ-004 Parameter PIPE, default 2, multiplier pipeline stages (1..4).
REQ-005 CLK  input  1  single clock, rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  input vector valid.
REQ-008 in_ready  output  1  stage accepts vector this cycle.
REQ-009 in_data  input  NCH*DW  channel k at bits k*DW+DW-1:k*DW.
REQ-010 out_valid  output  1  output vector valid.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 out_data  output  NCH*DW  scaled vector, same packing.
REQ-013 cfg_we  input  1  write coefficient-table entry.
REQ-014 cfg_addr  input  clog2(NCH)  channel index for write.
REQ-015 cfg_coef  input  CW  coefficient written.
REQ-016 cfg_bypass  input  1  bypass flag written with coefficient.
REQ-017 cfg_clr_sat  input  1  clears sat_sticky.
REQ-018 sat_sticky  output  NCH  per-channel saturation-occurred flag.

Function
REQ-019 Vector accepted on a rising CLK edge when in_valid && in_ready.
REQ-020 Global advance en = out_ready || !out_valid; in_ready SHALL equal en; all pipeline registers advance only when en.
REQ-021 Latency SHALL be PIPE+1 cycles from acceptance to out_valid with out_ready held high; throughput one vector per cycle.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-023 Non-bypass channel: mag_out = (mag_in*coef + 2^14) >> 15 (round half up), sign preserved.
REQ-024 If mag_out > 2^(DW-1)-1, output SHALL saturate to 2^(DW-1)-1 and set sat_sticky[k] at output time.
REQ-025 Bypass channel: output equals input word unchanged, same latency.
REQ-026 Any channel whose output magnitude is 0 SHALL output sign 0 (negative zero canonicalised), including bypass.
REQ-027 Coefficient and bypass used SHALL be those in the table at the acceptance edge, carried with the sample; later writes do not affect in-flight vectors.
REQ-028 cfg_we on the same edge as acceptance: accepted vector uses the old entry; next vector uses the new.
REQ-029 cfg_we with cfg_addr >= NCH SHALL be ignored.
REQ-030 cfg_clr_sat coincident with a new saturation: set wins for that channel.
REQ-031 Pipeline bubbles (in_valid low) SHALL propagate as out_valid low without altering held data semantics.

Reset
REQ-032 On RESET: out_valid=0, out_data=0, all pipeline valid bits=0, sat_sticky=0.
REQ-033 On RESET: every table entry coef=0x8000, bypass=1.
REQ-034 in_ready SHALL be 1 during and immediately after reset; RESET mid-operation discards all in-flight vectors.

Structure
REQ-035 Shared package holds DW/CW defaults, the Q1.15 ONE constant 0x8000, the rounding constant, and the sign-magnitude word typedef.
REQ-036 One sub-module, c_scale_lane: one channel's pipelined multiply/round/saturate/bypass, instantiated NCH times by generate.

Verification
REQ-037 Reset -> out_valid=0, sat_sticky=0; vector all channels 0x123 passes unchanged after PIPE+1 cycles.
REQ-038 Channel 2 coef=0x4000 bypass=0; magnitudes 100, 101, sign 1 -> outputs 0x832, 0x833 (50, 51 rounded).
REQ-039 Channel 3 coef=0xFFFF bypass=0; input 0x7FF -> 0x7FF, sat_sticky[3]=1; cfg_clr_sat -> 0.
REQ-040 Channel 6 coef=0x0001; input 0x801 -> 0x000 (negative zero canonicalised).
REQ-041 Streaming 10 vectors, out_ready low for 3 cycles mid-stream -> no loss/duplication, output held, order preserved.
REQ-042 cfg_we to channel 7 on acceptance edge of vector N -> vector N old coefficient, N+1 new; RESET asserted with 2 in flight -> none emerge.
